// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-addressed data memory; sub-word stores are read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW respond with respMisaligned and no memory access.
module load_store_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqStore,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  input  logic [31:0] reqPC,
  output logic        respValid,
  output logic [31:0] respRData,
  output logic        respMisaligned,
  output logic [31:0] memAddr,
  output logic        memReadEnable,
  input  logic [31:0] memReadData,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  output logic [31:0] memPC
);

  typedef enum logic [2:0] {IDLE, RD, SETUP, WR, RESP} lsuState_t;

  lsuState_t   stateQ, stateD;
  logic [2:0]  funct3Q;
  logic        storeQ;
  logic [31:0] wdataQ;
  logic        accept;
  logic        reqReserved;
  logic        reqMis;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic [31:0] mergeData;

  assign accept = (stateQ == IDLE) && reqValid;

  always_comb begin
    reqReserved = 1'b0;
    reqMis      = 1'b0;
    if (reqStore) reqReserved = (reqFunct3 > 3'b010);
    else          reqReserved = (reqFunct3 == 3'b011) || (reqFunct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    reqMis = !reqReserved &&
             (((reqFunct3[1:0] == 2'b01) && reqAddr[0]) ||
              ((reqFunct3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00)));
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD        = stateQ;
    reqReady      = 1'b0;
    respValid     = 1'b0;
    memReadEnable = 1'b0;
    case (stateQ)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (reqReserved || reqMis)                   stateD = RESP;
          else if (reqStore && (reqFunct3 == 3'b010))  stateD = SETUP;
          else                                         stateD = RD;
        end
      end
      RD: begin
        memReadEnable = 1'b1;
        stateD        = storeQ ? SETUP : RESP;
      end
      SETUP:   stateD = WR;
      WR:      stateD = RESP;
      RESP: begin
        respValid = 1'b1;
        stateD    = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Lane selection uses only the low address bits; a misaligned word access reads the containing word.
  always_comb begin
    byteSel = memReadData[7:0];
    case (memAddr[1:0])
      2'd1:    byteSel = memReadData[15:8];
      2'd2:    byteSel = memReadData[23:16];
      2'd3:    byteSel = memReadData[31:24];
      default: byteSel = memReadData[7:0];
    endcase
    halfSel = memAddr[1] ? memReadData[31:16] : memReadData[15:0];
    case (funct3Q)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = memReadData;
    endcase
  end

  always_comb begin
    mergeData = memReadData;
    if (funct3Q[1:0] == 2'b00) begin
      case (memAddr[1:0])
        2'd1:    mergeData[15:8]  = wdataQ[7:0];
        2'd2:    mergeData[23:16] = wdataQ[7:0];
        2'd3:    mergeData[31:24] = wdataQ[7:0];
        default: mergeData[7:0]   = wdataQ[7:0];
      endcase
    end else if (memAddr[1]) begin
      mergeData[31:16] = wdataQ[15:0];
    end else begin
      mergeData[15:0] = wdataQ[15:0];
    end
  end

  // Write-enable is a flop so the memory sees a glitch-free edge; reset clears it asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memWriteEnable <= 1'b0;
      memAddr        <= '0;
      memWriteData   <= '0;
      memPC          <= '0;
      respRData      <= '0;
      funct3Q        <= '0;
      storeQ         <= 1'b0;
      wdataQ         <= '0;
    end else begin
      memWriteEnable <= (stateD == WR);
      if (accept) begin
        memAddr   <= reqAddr;
        memPC     <= reqPC;
        funct3Q   <= reqFunct3;
        storeQ    <= reqStore;
        wdataQ    <= reqWData;
        respRData <= '0;
        if (stateD == SETUP) memWriteData <= reqWData;
      end
      if (stateQ == RD) begin
        if (storeQ) memWriteData <= mergeData;
        else        respRData    <= loadData;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misQ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       misQ <= 1'b0;
    else if (accept) misQ <= reqMis;
  end

  assign respMisaligned = respValid && misQ;
`else
  assign respMisaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: reference memory model plus per-cycle output comparison.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqStore = 1'b0;
  logic [2:0]  reqFunct3 = '0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWData = '0;
  logic [31:0] reqPC = '0;
  logic        respValid;
  logic [31:0] respRData;
  logic        respMisaligned;
  logic [31:0] memAddr;
  logic        memReadEnable;
  logic [31:0] memReadData;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memPC;

  load_store_unit dut (
    .clk(clk), .rstn(rstn),
    .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore), .reqFunct3(reqFunct3),
    .reqAddr(reqAddr), .reqWData(reqWData), .reqPC(reqPC),
    .respValid(respValid), .respRData(respRData), .respMisaligned(respMisaligned),
    .memAddr(memAddr), .memReadEnable(memReadEnable), .memReadData(memReadData),
    .memWriteEnable(memWriteEnable), .memWriteData(memWriteData), .memPC(memPC)
  );

  always #5 clk = ~clk;

  int errCount = 0;
  int chkCount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chkCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory the DUT talks to: combinational read, capture on write-enable rising edge.
  logic [31:0] bmem [0:1023];
  int          wrCount = 0;
  assign memReadData = bmem[memAddr[11:2]];

  always @(posedge memWriteEnable) begin
    bmem[memAddr[11:2]] = memWriteData;
    wrCount++;
  end

  int respCount = 0;
  always @(negedge clk) if (rstn && respValid) respCount++;

  // Reference model: architectural memory and per-transaction expectations.
  logic [31:0] refMem [0:1023];
  logic        mBusy = 1'b0;
  int          mCyc = 0;
  int          mLat = 0;
  int          mAccepts = 0;
  logic        mHasRd, mIsWr, mExpMis;
  logic [31:0] mExpR, mExpW, mExpAddr, mExpPC;

  function automatic logic [31:0] loadValue(input logic [31:0] w, input logic [1:0] lo, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b ^ 32'h80) - 32'h80;
      3'd1:    return (h ^ 32'h8000) - 32'h8000;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] storeValue(input logic [31:0] w, input logic [31:0] wd, input logic [1:0] lo, input logic [2:0] f3);
    int sh;
    case (f3)
      3'd0: begin
        sh = 8 * lo;
        return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end
      3'd1: begin
        sh = 16 * lo[1];
        return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mBusy = 1'b0;
      mCyc  = 0;
    end else if (mBusy) begin
      if (mCyc == mLat) mBusy = 1'b0;
      else begin
        mCyc++;
        if (mIsWr && mCyc == mLat - 1) refMem[mExpAddr[11:2]] = mExpW;
      end
    end else if (reqValid) begin
      logic res, mis;
      res = reqStore ? (reqFunct3 > 3'd2) : (reqFunct3 == 3'd3 || reqFunct3 >= 3'd6);
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = !res && ((((reqFunct3 == 3'd1) || (reqFunct3 == 3'd5)) && reqAddr[0]) ||
                     ((reqFunct3 == 3'd2) && (reqAddr[1:0] != 2'd0)));
`endif
      mExpAddr = reqAddr;
      mExpPC   = reqPC;
      mExpMis  = mis;
      mExpR    = 32'h0;
      mExpW    = 32'h0;
      mHasRd   = 1'b0;
      mIsWr    = 1'b0;
      if (res || mis) mLat = 1;
      else if (reqStore) begin
        mIsWr  = 1'b1;
        mHasRd = (reqFunct3 != 3'd2);
        mLat   = (reqFunct3 == 3'd2) ? 3 : 4;
        mExpW  = storeValue(refMem[reqAddr[11:2]], reqWData, reqAddr[1:0], reqFunct3);
      end else begin
        mHasRd = 1'b1;
        mLat   = 2;
        mExpR  = loadValue(refMem[reqAddr[11:2]], reqAddr[1:0], reqFunct3);
      end
      mBusy = 1'b1;
      mCyc  = 1;
      mAccepts++;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (mBusy) begin
        chk("reqReady busy", {31'd0, reqReady}, 32'd0);
        chk("respValid", {31'd0, respValid}, {31'd0, mCyc == mLat});
        chk("memWriteEnable", {31'd0, memWriteEnable}, {31'd0, mIsWr && (mCyc == mLat - 1)});
        chk("memReadEnable", {31'd0, memReadEnable}, {31'd0, mHasRd && (mCyc == 1)});
        chk("memAddr", memAddr, mExpAddr);
        chk("memPC", memPC, mExpPC);
        if (mIsWr && mCyc >= mLat - 2) chk("memWriteData", memWriteData, mExpW);
        if (mCyc == mLat) begin
          chk("respRData", respRData, mExpR);
          chk("respMisaligned", {31'd0, respMisaligned}, {31'd0, mExpMis});
        end
      end else begin
        chk("reqReady idle", {31'd0, reqReady}, 32'd1);
        chk("respValid idle", {31'd0, respValid}, 32'd0);
        chk("memWriteEnable idle", {31'd0, memWriteEnable}, 32'd0);
        chk("memReadEnable idle", {31'd0, memReadEnable}, 32'd0);
      end
    end
  end

  task automatic waitAccept(input int n, input string name);
    int k = 0;
    while (mAccepts == n && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, mAccepts - n, 32'd1);
  endtask

  task automatic doReq(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, output logic [31:0] rd, output logic mis);
    int n, k;
    @(negedge clk);
    reqStore = st; reqFunct3 = f3; reqAddr = a; reqWData = wd; reqPC = pc;
    reqValid = 1'b1;
    n = mAccepts;
    waitAccept(n, "accept");
    @(negedge clk);
    reqValid = 1'b0;
    k = 0;
    while (!respValid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("response arrives", {31'd0, respValid}, 32'd1);
    rd  = respRData;
    mis = respMisaligned;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          n, k, w0, a0, r0;
    for (int i = 0; i < 1024; i++) begin
      bmem[i]   = 32'h0;
      refMem[i] = 32'h0;
    end

    #12;
    chk("rst reqReady", {31'd0, reqReady}, 32'd1);
    chk("rst respValid", {31'd0, respValid}, 32'd0);
    chk("rst memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
    chk("rst memReadEnable", {31'd0, memReadEnable}, 32'd0);
    chk("rst memAddr", memAddr, 32'h0);
    chk("rst memWriteData", memWriteData, 32'h0);
    chk("rst memPC", memPC, 32'h0);
    chk("rst respRData", respRData, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    doReq(1'b1, 3'd2, 32'h10, 32'h12345678, 32'h100, rd, mis);
    chk("SW write count", wrCount, 32'd1);
    chk("SW mem 0x10", bmem[4], 32'h12345678);
    doReq(1'b0, 3'd2, 32'h10, 32'h0, 32'h104, rd, mis);
    chk("LW 0x10", rd, 32'h12345678);
    doReq(1'b1, 3'd0, 32'h11, 32'h000000AB, 32'h108, rd, mis);
    chk("SB write count", wrCount, 32'd2);
    chk("SB mem 0x10", bmem[4], 32'h1234AB78);

    doReq(1'b1, 3'd2, 32'h20, 32'h8000FF80, 32'h10C, rd, mis);
    doReq(1'b0, 3'd0, 32'h20, 32'h0, 32'h110, rd, mis);
    chk("LB 0x20", rd, 32'hFFFFFF80);
    doReq(1'b0, 3'd4, 32'h20, 32'h0, 32'h114, rd, mis);
    chk("LBU 0x20", rd, 32'h00000080);
    doReq(1'b0, 3'd1, 32'h22, 32'h0, 32'h118, rd, mis);
    chk("LH 0x22", rd, 32'hFFFF8000);
    doReq(1'b0, 3'd5, 32'h21, 32'h0, 32'h11C, rd, mis);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("LHU 0x21 trap data", rd, 32'h0);
    chk("LHU 0x21 trap flag", {31'd0, mis}, 32'd1);
`else
    chk("LHU 0x21", rd, 32'h0000FF80);
`endif

    doReq(1'b1, 3'd2, 32'h30, 32'h11223344, 32'h120, rd, mis);
    doReq(1'b1, 3'd1, 32'h32, 32'h0000BEEF, 32'h124, rd, mis);
    chk("SH upper half", bmem[12], 32'hBEEF3344);

    w0 = wrCount;
    doReq(1'b0, 3'd3, 32'h10, 32'h0, 32'h128, rd, mis);
    chk("reserved load data", rd, 32'h0);
    doReq(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h12C, rd, mis);
    chk("reserved store no write", wrCount - w0, 32'd0);
    chk("reserved store mem intact", bmem[4], 32'h1234AB78);

    w0 = wrCount;
    doReq(1'b0, 3'd2, 32'h13, 32'h0, 32'h130, rd, mis);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("LW 0x13 trap data", rd, 32'h0);
    chk("LW 0x13 trap flag", {31'd0, mis}, 32'd1);
`else
    chk("LW 0x13 unrotated", rd, 32'h1234AB78);
    chk("LW 0x13 flag", {31'd0, mis}, 32'd0);
`endif

    // Reset pulse while SH 0xBEEF to 0x30 is in WR.
    w0 = wrCount;
    @(negedge clk);
    reqStore = 1'b1; reqFunct3 = 3'd1; reqAddr = 32'h30; reqWData = 32'h0000BEEF; reqPC = 32'h300;
    reqValid = 1'b1;
    n = mAccepts;
    waitAccept(n, "SH accept");
    @(negedge clk);
    reqValid = 1'b0;
    k = 0;
    while (mCyc != 3 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("SH reached WR", mCyc, 32'd3);
    #1 rstn = 1'b0;
    #1;
    chk("rst-in-WR memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
    chk("rst-in-WR reqReady", {31'd0, reqReady}, 32'd1);
    chk("rst-in-WR respValid", {31'd0, respValid}, 32'd0);
    chk("rst-in-WR memReadEnable", {31'd0, memReadEnable}, 32'd0);
    chk("rst-in-WR memAddr", memAddr, 32'h0);
    chk("rst-in-WR memWriteData", memWriteData, 32'h0);
    chk("rst-in-WR memPC", memPC, 32'h0);
    chk("rst-in-WR respRData", respRData, 32'h0);
    chk("rst-in-WR one write", wrCount - w0, 32'd1);
    chk("rst-in-WR mem 0x30", bmem[12], 32'hBEEFBEEF);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst-in-WR no duplicate", wrCount - w0, 32'd1);

    // Continuous reqValid with alternating SW/LW.
    a0 = mAccepts; r0 = respCount; w0 = wrCount;
    @(negedge clk);
    reqValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reqStore  = (i % 2 == 0);
      reqFunct3 = 3'd2;
      reqAddr   = 32'h40 + 32'(4 * (i / 2));
      reqWData  = 32'hA0000000 + 32'(i);
      reqPC     = 32'h200 + 32'(i);
      n = mAccepts;
      waitAccept(n, "stream accept");
      @(negedge clk);
    end
    reqValid = 1'b0;
    repeat (8) @(negedge clk);
    chk("stream accepts", mAccepts - a0, 32'd6);
    chk("stream responses", respCount - r0, 32'd6);
    chk("stream writes", wrCount - w0, 32'd3);
    chk("stream mem 0x48", bmem[18], 32'hA0000004);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule
